// File: rtl/line_mem_responder.sv
// ============================================================================
// Module   : line_mem_responder
// Brief    : Line-granular memory responder with fixed acceptance-to-response
//            latency. Define LINE_MEM_RESP_ERR_EN to add address range
//            checking and the resp_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_mem_responder #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 5,
    parameter int DEPTH_LOG2    = 6,
    parameter int LATENCY       = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     command_valid,
    input  logic                                     command_store,
    input  logic                                     command_rready,
    input  logic [ADDR_WIDTH-1:0]                    command_addr,
    input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_to_bus,
`ifdef LINE_MEM_RESP_ERR_EN
    output logic                                     resp_err,
`endif
    output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0] data_from_bus,
    output logic                                     bus_valid,
    output logic                                     bus_ready
);

    localparam int c_LINE_W = DATA_WIDTH * (2**OFFSET_LENGTH);
    localparam int c_DEPTH  = 2**DEPTH_LOG2;
    localparam int c_IDX_LO = OFFSET_LENGTH;
    localparam int c_IDX_HI = OFFSET_LENGTH + DEPTH_LOG2 - 1;
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state_q,     w_state_d;
    logic [c_CNT_W-1:0]      r_count_q,     w_count_d;
    logic [DEPTH_LOG2-1:0]   r_idx_q,       w_idx_d;
    logic                    r_store_q,     w_store_d;
    logic [c_LINE_W-1:0]     r_line_q,      w_line_d;
    logic                    r_err_q,       w_err_d;
    logic                    r_bus_valid_q, w_bus_valid_d;
    logic                    r_bus_ready_q, w_bus_ready_d;
    logic [c_LINE_W-1:0]     r_data_q,      w_data_d;
    logic                    r_resp_err_q,  w_resp_err_d;

    logic [c_LINE_W-1:0]     r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0]   w_cmd_idx;
    logic                    w_cmd_err;
    logic                    w_enter_resp;
    logic [DEPTH_LOG2-1:0]   w_sel_idx;
    logic                    w_sel_store;
    logic [c_LINE_W-1:0]     w_sel_line;
    logic                    w_sel_err;
    logic                    w_mem_we;
    logic                    w_addr_unused;

    assign w_cmd_idx = command_addr[c_IDX_HI:c_IDX_LO];

`ifdef LINE_MEM_RESP_ERR_EN
    assign w_cmd_err     = |command_addr[ADDR_WIDTH-1:c_IDX_HI+1];
    assign w_addr_unused = ^command_addr[c_IDX_LO-1:0];
    assign resp_err      = r_resp_err_q;
`else
    // Upper address bits alias onto the same line when range checking is off.
    assign w_cmd_err     = 1'b0;
    assign w_addr_unused = ^{command_addr[ADDR_WIDTH-1:c_IDX_HI+1], command_addr[c_IDX_LO-1:0]};
`endif

    assign data_from_bus = r_data_q;
    assign bus_valid     = r_bus_valid_q;
    assign bus_ready     = r_bus_ready_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_count_d     = r_count_q;
        w_idx_d       = r_idx_q;
        w_store_d     = r_store_q;
        w_line_d      = r_line_q;
        w_err_d       = r_err_q;
        w_bus_valid_d = r_bus_valid_q;
        w_bus_ready_d = r_bus_ready_q;
        w_data_d      = r_data_q;
        w_resp_err_d  = r_resp_err_q;
        w_enter_resp  = 1'b0;
        w_sel_idx     = r_idx_q;
        w_sel_store   = r_store_q;
        w_sel_line    = r_line_q;
        w_sel_err     = r_err_q;
        w_mem_we      = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (command_valid) begin
                    w_idx_d   = w_cmd_idx;
                    w_store_d = command_store;
                    w_line_d  = data_to_bus;
                    w_err_d   = w_cmd_err;
                    // Single-cycle latency bypasses WAIT and responds from the live command.
                    if (LATENCY == 1) begin
                        w_enter_resp = 1'b1;
                        w_sel_idx    = w_cmd_idx;
                        w_sel_store  = command_store;
                        w_sel_line   = data_to_bus;
                        w_sel_err    = w_cmd_err;
                    end else begin
                        w_state_d = S_WAIT;
                        w_count_d = c_CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_count_q <= c_CNT_ONE) begin
                    w_enter_resp = 1'b1;
                    w_count_d    = '0;
                end else begin
                    w_count_d = r_count_q - c_CNT_ONE;
                end
            end
            S_RESP: begin
                if (r_store_q) begin
                    w_bus_ready_d = 1'b0;
                    w_resp_err_d  = 1'b0;
                    w_state_d     = S_IDLE;
                end else if (command_rready) begin
                    w_bus_valid_d = 1'b0;
                    w_data_d      = '0;
                    w_resp_err_d  = 1'b0;
                    w_state_d     = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // The array write lands on the same edge that raises bus_ready.
        if (w_enter_resp) begin
            w_state_d    = S_RESP;
            w_resp_err_d = w_sel_err;
            if (w_sel_store) begin
                w_bus_ready_d = 1'b1;
                w_mem_we      = ~w_sel_err;
            end else begin
                w_bus_valid_d = 1'b1;
                w_data_d      = w_sel_err ? '0 : r_mem[w_sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_IDLE;
            r_count_q     <= '0;
            r_bus_valid_q <= 1'b0;
            r_bus_ready_q <= 1'b0;
            r_data_q      <= '0;
            r_resp_err_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_count_q     <= w_count_d;
            r_bus_valid_q <= w_bus_valid_d;
            r_bus_ready_q <= w_bus_ready_d;
            r_data_q      <= w_data_d;
            r_resp_err_q  <= w_resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        r_idx_q   <= w_idx_d;
        r_store_q <= w_store_d;
        r_line_q  <= w_line_d;
        r_err_q   <= w_err_d;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[w_sel_idx] <= w_sel_line;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder: scoreboarded store/load transactions with
// a line model. Define LINE_MEM_RESP_ERR_EN to exercise the range-check build.
`default_nettype none

module tb_line_mem_responder;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int OL   = 5;
    localparam int DL   = 6;
    localparam int LAT  = 4;
    localparam int LINE = DW * (2**OL);

    typedef logic [LINE-1:0] line_t;
    typedef struct {
        bit    st;
        bit    err;
        int    idx;
        line_t data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          command_valid = 1'b0;
    logic          command_store = 1'b0;
    logic          command_rready = 1'b0;
    logic [AW-1:0] command_addr = '0;
    line_t         data_to_bus = '0;
    line_t         data_from_bus;
    logic          bus_valid;
    logic          bus_ready;
`ifdef LINE_MEM_RESP_ERR_EN
    logic          resp_err;
`endif

    exp_t  sb[$];
    line_t model[int];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    line_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL), .DEPTH_LOG2(DL), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .command_valid(command_valid),
        .command_store(command_store),
        .command_rready(command_rready),
        .command_addr(command_addr),
        .data_to_bus(data_to_bus),
`ifdef LINE_MEM_RESP_ERR_EN
        .resp_err(resp_err),
`endif
        .data_from_bus(data_from_bus),
        .bus_valid(bus_valid),
        .bus_ready(bus_ready)
    );

    always #5 clk = ~clk;

    // Protocol invariants checked every cycle once out of initial reset.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
                n_fail++;
                $display("FAIL exclusive_valid_ready: valid=%b ready=%b required not both 1", bus_valid, bus_ready);
            end
            n_checks++;
            if (bus_valid !== 1'b1 && data_from_bus !== '0) begin
                n_fail++;
                $display("FAIL idle_data_zero: data word0=%h required 0 while bus_valid=%b", data_from_bus[63:0], bus_valid);
            end
        end
    end

    function automatic line_t make_line(input logic [63:0] base);
        line_t l;
        for (int i = 0; i < 2**OL; i++) l[i*DW +: DW] = base + 64'(i);
        return l;
    endfunction

    function automatic int first_diff(input line_t a, input line_t b);
        for (int i = 0; i < 2**OL; i++) if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return 0;
    endfunction

    function automatic logic [63:0] word_of(input line_t l, input int i);
        return l[i*DW +: DW];
    endfunction

    function automatic bit addr_err(input logic [AW-1:0] a);
`ifdef LINE_MEM_RESP_ERR_EN
        return |a[AW-1:OL+DL];
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_cmd(input bit st, input logic [AW-1:0] a, input line_t d, input bit rr);
        exp_t e;
        e.st  = st;
        e.err = addr_err(a);
        e.idx = int'(a[OL+DL-1:OL]);
        if (st) e.data = d;
        else    e.data = (e.err || !model.exists(e.idx)) ? '0 : model[e.idx];
        sb.push_back(e);
        command_valid  = 1'b1;
        command_store  = st;
        command_addr   = a;
        data_to_bus    = d;
        command_rready = rr;
    endtask

    // Waits (bounded) for the first response; k = -1 if none arrived.
    task automatic collect(output int k, output logic v, output logic r, output line_t d, output logic e);
        k = -1; v = 1'b0; r = 1'b0; d = '0; e = 1'b0;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(negedge clk);
            if (c == 1) command_valid = 1'b0;
            if (bus_valid === 1'b1 || bus_ready === 1'b1) begin
                k = c; v = bus_valid; r = bus_ready; d = data_from_bus;
`ifdef LINE_MEM_RESP_ERR_EN
                e = resp_err;
`endif
                break;
            end
        end
    endtask

    task automatic run_txn(input bit st, input logic [AW-1:0] a, input line_t d, input bit rr,
                           output int k, output logic v, output logic r, output line_t got,
                           output logic e, output exp_t ex);
        drive_cmd(st, a, d, rr);
        collect(k, v, r, got, e);
        ex = sb.pop_front();
        if (ex.st && !ex.err) model[ex.idx] = ex.data;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
        n_checks++;
        if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus_ready); end
        n_checks++;
        if (data_from_bus !== '0) begin n_fail++; $display("FAIL reset_data: word0 got %h want 0", data_from_bus[63:0]); end
`ifdef LINE_MEM_RESP_ERR_EN
        n_checks++;
        if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", resp_err); end
`endif
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_store_load;
        int k; logic v, r, e; line_t got; exp_t ex;
        run_txn(1'b1, 64'h40, make_line(64'h1000), 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || r !== 1'b1 || v !== 1'b0) begin
            n_fail++; $display("FAIL store_latency: cycle %0d ready=%b valid=%b want cycle %0d ready=1 valid=0", k, r, v, LAT);
        end
        @(negedge clk);
        n_checks++;
        if (bus_ready !== 1'b0) begin n_fail++; $display("FAIL store_pulse: ready got %b want 0", bus_ready); end
        run_txn(1'b0, 64'h40, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || v !== 1'b1) begin n_fail++; $display("FAIL load_latency: cycle %0d valid=%b want cycle %0d valid=1", k, v, LAT); end
        n_checks++;
        if (got !== ex.data) begin
            n_fail++; $display("FAIL load_data: word %0d got %h want %h", first_diff(got, ex.data),
                               word_of(got, first_diff(got, ex.data)), word_of(ex.data, first_diff(got, ex.data)));
        end
        n_checks++;
        if (word_of(got, 5) !== 64'h1005) begin n_fail++; $display("FAIL load_word5: got %h want 1005", word_of(got, 5)); end
        @(negedge clk);
        n_checks++;
        if (bus_valid !== 1'b0) begin n_fail++; $display("FAIL load_release: valid got %b want 0", bus_valid); end
    endtask

    task automatic test_rready_stall;
        int k; logic v, r, e; line_t got; exp_t ex;
        run_txn(1'b1, 64'h20, make_line(64'h2000), 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || r !== 1'b1) begin n_fail++; $display("FAIL stall_store: cycle %0d ready=%b want cycle %0d ready=1", k, r, LAT); end
        @(negedge clk);
        run_txn(1'b0, 64'h20, '0, 1'b0, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || v !== 1'b1 || got !== ex.data) begin
            n_fail++; $display("FAIL stall_load: cycle %0d valid=%b word0 %h want cycle %0d valid=1 word0 %h", k, v, got[63:0], LAT, ex.data[63:0]);
        end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus_valid !== 1'b1 || data_from_bus !== ex.data) begin
                n_fail++; $display("FAIL stall_hold%0d: valid=%b word0 %h want valid=1 word0 %h", j, bus_valid, data_from_bus[63:0], ex.data[63:0]);
            end
            if (j == 3) command_rready = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if (bus_valid !== 1'b0 || data_from_bus !== '0) begin
            n_fail++; $display("FAIL stall_release: valid=%b word0 %h want valid=0 data 0", bus_valid, data_from_bus[63:0]);
        end
    endtask

    task automatic test_back_to_back;
        int k; logic v, r, e; line_t got; exp_t ex;
        drive_cmd(1'b0, 64'h40, '0, 1'b1);
        collect(k, v, r, got, e);
        ex = sb.pop_front();
        n_checks++;
        if (k != LAT || v !== 1'b1 || got !== ex.data) begin
            n_fail++; $display("FAIL b2b_load: cycle %0d valid=%b word0 %h want cycle %0d valid=1 word0 %h", k, v, got[63:0], LAT, ex.data[63:0]);
        end
        // Store presented during the load's completion cycle and held.
        drive_cmd(1'b1, 64'h80, make_line(64'h4000), 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus_valid !== 1'b0 || bus_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap: valid=%b ready=%b want both 0", bus_valid, bus_ready);
        end
        collect(k, v, r, got, e);
        ex = sb.pop_front();
        model[ex.idx] = ex.data;
        n_checks++;
        if (k != LAT || r !== 1'b1) begin n_fail++; $display("FAIL b2b_store: cycle %0d ready=%b want cycle %0d ready=1", k, r, LAT); end
        @(negedge clk);
        run_txn(1'b0, 64'h80, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (got !== ex.data) begin n_fail++; $display("FAIL b2b_readback: word0 got %h want %h", got[63:0], ex.data[63:0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k; logic v, r, e; line_t got; exp_t ex; bit seen;
        run_txn(1'b1, 64'h60, make_line(64'h3000), 1'b1, k, v, r, got, e, ex);
        @(negedge clk);
        command_valid = 1'b1; command_store = 1'b1; command_addr = 64'h60;
        data_to_bus = make_line(64'hBAD0);
        @(negedge clk);
        command_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus_valid !== 1'b0 || bus_ready !== 1'b0 || data_from_bus !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: valid=%b ready=%b word0 %h want all 0", bus_valid, bus_ready, data_from_bus[63:0]);
        end
        seen = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_no_ready: ready seen=1 want 0"); end
        run_txn(1'b0, 64'h60, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || got !== ex.data) begin
            n_fail++; $display("FAIL midreset_contents: cycle %0d word0 %h want cycle %0d word0 %h", k, got[63:0], LAT, ex.data[63:0]);
        end
        @(negedge clk);
    endtask

`ifdef LINE_MEM_RESP_ERR_EN
    task automatic test_addr_range;
        int k; logic v, r, e; line_t got; exp_t ex;
        run_txn(1'b1, 64'h1_0000_0040, make_line(64'hDEAD0000), 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || r !== 1'b1 || e !== 1'b1) begin
            n_fail++; $display("FAIL err_store: cycle %0d ready=%b err=%b want cycle %0d ready=1 err=1", k, r, e, LAT);
        end
        @(negedge clk);
        run_txn(1'b0, 64'h40, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (got !== ex.data || word_of(got, 0) !== 64'h1000 || e !== 1'b0) begin
            n_fail++; $display("FAIL err_unchanged: word0 %h err=%b want word0 1000 err=0", got[63:0], e);
        end
        @(negedge clk);
        run_txn(1'b0, 64'h8000_0000_0040, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (v !== 1'b1 || got !== '0 || e !== 1'b1) begin
            n_fail++; $display("FAIL err_load: valid=%b word0 %h err=%b want valid=1 data 0 err=1", v, got[63:0], e);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_addr_range;
        int k; logic v, r, e; line_t got; exp_t ex;
        run_txn(1'b0, 64'hABC0_0000_0000_005F, '0, 1'b1, k, v, r, got, e, ex);
        n_checks++;
        if (k != LAT || got !== ex.data || word_of(got, 0) !== 64'h1000) begin
            n_fail++; $display("FAIL alias_load: cycle %0d word0 %h want cycle %0d word0 1000", k, got[63:0], LAT);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_random;
        int k; logic v, r, e; line_t got; exp_t ex;
        logic [AW-1:0] a, up;
        for (int n = 0; n < 6; n++) begin
`ifdef LINE_MEM_RESP_ERR_EN
            up = '0;
`else
            up = {$urandom, $urandom};
`endif
            a = (up & ~64'h7FF) | (64'($urandom_range(63, 8)) << OL) | 64'($urandom_range(31, 0));
            run_txn(1'b1, a, make_line({$urandom, $urandom}), 1'b1, k, v, r, got, e, ex);
            n_checks++;
            if (k != LAT || r !== 1'b1) begin n_fail++; $display("FAIL rand_store%0d: cycle %0d ready=%b", n, k, r); end
            @(negedge clk);
            a = {a[AW-1:OL], 5'(~a[OL-1:0])};
            run_txn(1'b0, a, '0, 1'b1, k, v, r, got, e, ex);
            n_checks++;
            if (k != LAT || v !== 1'b1 || got !== ex.data) begin
                n_fail++; $display("FAIL rand_load%0d: cycle %0d valid=%b word0 %h want %h", n, k, v, got[63:0], ex.data[63:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_rready_stall();
        test_back_to_back();
        test_reset_mid();
        test_addr_range();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
